dmem_arbiter: RTL and testbench

- Shares the single byte-addressed, big-endian 32-bit data memory between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is the external loader/debug port that preloads and dumps the merge-sort array.
- Performs round-robin arbitration, a lock for port-0 read-modify-write, and alignment/bounds checking.
- Drives the memory's value/write/read/address inputs and returns a registered read response.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 92 +++++++++
 tb/tb_dmem_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default size
// and the word-access legality check.
package dmem_pkg;

    localparam int DEPTH_DEFAULT = 4096;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK0 = 1'b1
    } arb_state_t;

    // last_word is the highest legal word byte address (DEPTH-4).
    function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] last_word);
        return (addr[1:0] == 2'b00) && (addr <= last_word);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side strobes of the
// data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic              p0_lock;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [31:0]       p0_rdata;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [31:0]       p1_rdata;
    logic              p1_err;

    logic [31:0]       mem_value;
    logic              mem_esc;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_value, mem_esc, mem_read, mem_addr,
        output mem_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_value, mem_esc, mem_read, mem_addr,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker; the pointer names the port that wins a tie
// and moves to the other port after every grant.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the shared big-endian data memory between the MEM stage (port 0,
// with read-modify-write lock) and the loader/debug port (port 1).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = 32
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [63:0] LAST_WORD = 64'(DEPTH - 4);

    arb_state_t        state;
    logic [1:0]        req_eff;
    logic [1:0]        gnt;
    logic              granted;
    logic              win_we;
    logic              win_legal;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic [ADDR_W-1:0] addr_hold;
    logic [31:0]       value_hold;
    logic [1:0]        vld_p1;
    logic              err_p1;
    logic [31:0]       rdata_p1;

    // While locked only port 0 may compete; nothing is granted during reset.
    always_comb begin
        req_eff = 2'b00;
        if (!reset) begin
            req_eff[0] = bus.p0_req;
            req_eff[1] = bus.p1_req && (state == ARB);
        end
    end

    rr_arb2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (req_eff),
        .advance (|req_eff),
        .gnt     (gnt)
    );

    assign granted   = |gnt;
    assign win_we    = gnt[1] ? bus.p1_we    : bus.p0_we;
    assign win_addr  = gnt[1] ? bus.p1_addr  : bus.p0_addr;
    assign win_wdata = gnt[1] ? bus.p1_wdata : bus.p0_wdata;
    assign win_legal = addr_legal(64'(win_addr), LAST_WORD);

    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];
    assign bus.mem_esc   = granted &  win_we & win_legal;
    assign bus.mem_read  = granted & ~win_we & win_legal;
    assign bus.mem_addr  = granted ? win_addr  : addr_hold;
    assign bus.mem_value = granted ? win_wdata : value_hold;

    // ---- grant edge -> response stage ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            vld_p1     <= 2'b00;
            err_p1     <= 1'b0;
            rdata_p1   <= '0;
            addr_hold  <= '0;
            value_hold <= '0;
        end else begin
            vld_p1 <= gnt;
            if (granted) begin
                addr_hold  <= win_addr;
                value_hold <= win_wdata;
                err_p1     <= ~win_legal;
                rdata_p1   <= bus.mem_read ? bus.mem_rdata : '0;
            end
            case (state)
                ARB:     if (gnt[0] &&  bus.p0_lock) state <= LOCK0;
                LOCK0:   if (gnt[0] && !bus.p0_lock) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    assign bus.p0_rvalid = vld_p1[0];
    assign bus.p1_rvalid = vld_p1[1];
    assign bus.p0_rdata  = rdata_p1;
    assign bus.p1_rdata  = rdata_p1;
    assign bus.p0_err    = err_p1 & vld_p1[0];
    assign bus.p1_err    = err_p1 & vld_p1[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of arbitration, locking and memory.
module tb_dmem_arbiter;

    localparam int DEPTH = 4096;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Byte-wide big-endian memory answering the arbiter's strobes.
    logic [7:0]  mem [0:DEPTH-1];
    logic [11:0] rix;
    assign rix = bus.mem_addr[11:0];
    always_comb begin
        bus.mem_rdata = 32'h0;
        if (bus.mem_addr <= 32'(DEPTH - 4))
            bus.mem_rdata = {mem[rix], mem[rix + 12'd1], mem[rix + 12'd2], mem[rix + 12'd3]};
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] ref_mem [int];
    int          m_ptr;
    bit          m_locked;
    logic [31:0] m_last_addr, m_last_val;

    // Requester drive values
    logic        d0_req, d0_we, d0_lock, d1_req, d1_we;
    logic [31:0] d0_addr, d0_wdata, d1_addr, d1_wdata;

    // Observed and expected values of the last cycle
    logic [1:0]  obs_gnt, obs_rv, exp_gnt;
    logic        obs_esc, obs_read, obs_err0, obs_err1;
    logic [31:0] obs_maddr, obs_mval, obs_rd0, obs_rd1;
    logic        exp_esc, exp_read, exp_err;
    logic [31:0] exp_maddr, exp_mval, exp_rdata;
    int          exp_win;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 32'h0;
    endfunction

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[int'(a)] = v;
        mem[a[11:0]]         = v[31:24];
        mem[a[11:0] + 12'd1] = v[23:16];
        mem[a[11:0] + 12'd2] = v[15:8];
        mem[a[11:0] + 12'd3] = v[7:0];
    endtask

    task automatic model_reset();
        m_ptr = 0; m_locked = 1'b0; m_last_addr = 32'h0; m_last_val = 32'h0;
    endtask

    task automatic drive_bus();
        bus.p0_req = d0_req; bus.p0_we = d0_we; bus.p0_lock = d0_lock;
        bus.p0_addr = d0_addr; bus.p0_wdata = d0_wdata;
        bus.p1_req = d1_req; bus.p1_we = d1_we;
        bus.p1_addr = d1_addr; bus.p1_wdata = d1_wdata;
    endtask

    task automatic apply_reset();
        reset = 1'b1; d0_req = 1'b0; d1_req = 1'b0; d0_lock = 1'b0;
        drive_bus();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: drive at the falling edge, sample grant-cycle outputs before
    // the rising edge, sample the response after it, then advance the model.
    task automatic tick();
        logic [31:0] a, wd;
        logic        we, lg;
        a = 32'h0; wd = 32'h0; we = 1'b0; lg = 1'b0;
        drive_bus();
        #1;
        obs_gnt = {bus.p1_gnt, bus.p0_gnt};
        obs_esc = bus.mem_esc; obs_read = bus.mem_read;
        obs_maddr = bus.mem_addr; obs_mval = bus.mem_value;
        exp_win = -1;
        if (m_locked) begin
            if (d0_req) exp_win = 0;
        end else if (d0_req && d1_req) exp_win = m_ptr;
        else if (d0_req) exp_win = 0;
        else if (d1_req) exp_win = 1;
        exp_gnt = 2'b00; exp_esc = 1'b0; exp_read = 1'b0; exp_err = 1'b0;
        exp_rdata = 32'h0; exp_maddr = m_last_addr; exp_mval = m_last_val;
        if (exp_win >= 0) begin
            a  = (exp_win == 1) ? d1_addr  : d0_addr;
            wd = (exp_win == 1) ? d1_wdata : d0_wdata;
            we = (exp_win == 1) ? d1_we    : d0_we;
            lg = (a % 32'd4 == 32'd0) && (a <= 32'(DEPTH - 4));
            exp_gnt   = (exp_win == 1) ? 2'b10 : 2'b01;
            exp_esc   = we && lg;
            exp_read  = !we && lg;
            exp_err   = !lg;
            exp_rdata = (!we && lg) ? ref_rd(a) : 32'h0;
            exp_maddr = a;
            exp_mval  = wd;
        end
        @(posedge clock);
        if (obs_esc) begin
            mem[obs_maddr[11:0]]         = obs_mval[31:24];
            mem[obs_maddr[11:0] + 12'd1] = obs_mval[23:16];
            mem[obs_maddr[11:0] + 12'd2] = obs_mval[15:8];
            mem[obs_maddr[11:0] + 12'd3] = obs_mval[7:0];
        end
        #1;
        obs_rv = {bus.p1_rvalid, bus.p0_rvalid};
        obs_rd0 = bus.p0_rdata; obs_rd1 = bus.p1_rdata;
        obs_err0 = bus.p0_err; obs_err1 = bus.p1_err;
        if (exp_win >= 0) begin
            if (we && lg) ref_mem[int'(a)] = wd;
            if (exp_win == 0) m_locked = d0_lock;
            m_ptr = 1 - exp_win;
            m_last_addr = a; m_last_val = wd;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d0_req = 1'b1; d0_we = 1'b0; d0_lock = 1'b1; d0_addr = 32'h0; d0_wdata = 32'h1;
        d1_req = 1'b1; d1_we = 1'b1; d1_addr = 32'h4; d1_wdata = 32'h2;
        drive_bus();
        repeat (2) @(negedge clock);
        #1;
        n_checks++;
        if ({bus.p1_gnt, bus.p0_gnt} !== 2'b00) begin
            n_errors++; $display("FAIL reset_gnt: got %b want 00", {bus.p1_gnt, bus.p0_gnt});
        end
        n_checks++;
        if ({bus.p1_rvalid, bus.p0_rvalid, bus.p1_err, bus.p0_err, bus.mem_esc, bus.mem_read} !== 6'b0) begin
            n_errors++; $display("FAIL reset_strobes: got %b want 000000",
                {bus.p1_rvalid, bus.p0_rvalid, bus.p1_err, bus.p0_err, bus.mem_esc, bus.mem_read});
        end
        n_checks++;
        if ({bus.p0_rdata, bus.p1_rdata, bus.mem_addr, bus.mem_value} !== 128'h0) begin
            n_errors++; $display("FAIL reset_data: rdata %h/%h addr %h value %h want all 0",
                bus.p0_rdata, bus.p1_rdata, bus.mem_addr, bus.mem_value);
        end
        @(negedge clock);
        d0_req = 1'b0; d1_req = 1'b0; d0_lock = 1'b0;
        drive_bus();
        reset = 1'b0;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_single_read();
        preload(32'd0, 32'h00000001);
        d0_req = 1'b1; d0_we = 1'b0; d0_lock = 1'b0; d0_addr = 32'd0;
        tick();
        n_checks++;
        if (obs_gnt !== 2'b01 || obs_read !== 1'b1) begin
            n_errors++; $display("FAIL single_grant: gnt %b read %b want 01 1", obs_gnt, obs_read);
        end
        n_checks++;
        if (obs_rv !== 2'b01 || obs_rd0 !== 32'h00000001 || obs_err0 !== 1'b0) begin
            n_errors++; $display("FAIL single_resp: rv %b rdata %h err %b want 01 00000001 0", obs_rv, obs_rd0, obs_err0);
        end
        d0_req = 1'b0;
        tick();
        n_checks++;
        if (obs_rv !== 2'b00) begin
            n_errors++; $display("FAIL single_pulse: rv %b want 00", obs_rv);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        preload(32'd4, 32'h00000002);
        preload(32'd8, 32'h00000005);
        d0_req = 1'b1; d0_we = 1'b0; d0_lock = 1'b0; d0_addr = 32'd4;
        d1_req = 1'b1; d1_we = 1'b0; d1_addr = 32'd8;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (obs_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_errors++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, obs_gnt,
                    (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (i == 0) begin
                n_checks++;
                if (obs_rd0 !== 32'h00000002) begin
                    n_errors++; $display("FAIL contention_p0_data: got %h want 00000002", obs_rd0);
                end
            end
            if (i == 1) begin
                n_checks++;
                if (obs_rv !== 2'b10 || obs_rd1 !== 32'h00000005) begin
                    n_errors++; $display("FAIL contention_p1_data: rv %b rdata %h want 10 00000005", obs_rv, obs_rd1);
                end
            end
        end
        d0_req = 1'b0; d1_req = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        d1_req = 1'b1; d1_we = 1'b1; d1_addr = 32'd12; d1_wdata = 32'hDEADBEEF;
        tick();
        n_checks++;
        if (obs_gnt !== 2'b10 || obs_esc !== 1'b1 || obs_maddr !== 32'd12 || obs_mval !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL write_strobe: gnt %b esc %b addr %h value %h want 10 1 0000000c deadbeef",
                obs_gnt, obs_esc, obs_maddr, obs_mval);
        end
        n_checks++;
        if (obs_rv !== 2'b10 || obs_rd1 !== 32'h0 || obs_err1 !== 1'b0) begin
            n_errors++; $display("FAIL write_ack: rv %b rdata %h err %b want 10 00000000 0", obs_rv, obs_rd1, obs_err1);
        end
        n_checks++;
        if ({mem[12], mem[13], mem[14], mem[15]} !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL write_bytes: got %h want deadbeef", {mem[12], mem[13], mem[14], mem[15]});
        end
        d1_req = 1'b0;
        d0_req = 1'b1; d0_we = 1'b0; d0_lock = 1'b0; d0_addr = 32'd12;
        tick();
        n_checks++;
        if (obs_rv !== 2'b01 || obs_rd0 !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL write_readback: rv %b rdata %h want 01 deadbeef", obs_rv, obs_rd0);
        end
        d0_req = 1'b0;
    endtask

    task automatic test_errors();
        preload(32'd4092, 32'hA1B2C3D4);
        d0_req = 1'b1; d0_we = 1'b0; d0_lock = 1'b0; d0_addr = 32'd2;
        tick();
        n_checks++;
        if (obs_gnt !== 2'b01 || obs_read !== 1'b0 || obs_esc !== 1'b0) begin
            n_errors++; $display("FAIL err_misaligned_strobe: gnt %b read %b esc %b want 01 0 0", obs_gnt, obs_read, obs_esc);
        end
        n_checks++;
        if (obs_rv !== 2'b01 || obs_err0 !== 1'b1 || obs_rd0 !== 32'h0) begin
            n_errors++; $display("FAIL err_misaligned_resp: rv %b err %b rdata %h want 01 1 00000000", obs_rv, obs_err0, obs_rd0);
        end
        d0_req = 1'b0;
        d1_req = 1'b1; d1_we = 1'b1; d1_addr = 32'd4094; d1_wdata = 32'h11223344;
        tick();
        n_checks++;
        if (obs_esc !== 1'b0 || obs_rv !== 2'b10 || obs_err1 !== 1'b1) begin
            n_errors++; $display("FAIL err_write_top: esc %b rv %b err %b want 0 10 1", obs_esc, obs_rv, obs_err1);
        end
        n_checks++;
        if (mem_word(12'd4092) !== 32'hA1B2C3D4) begin
            n_errors++; $display("FAIL err_write_unchanged: got %h want a1b2c3d4", mem_word(12'd4092));
        end
        d1_req = 1'b0;
        d0_req = 1'b1; d0_addr = 32'd4092;
        tick();
        n_checks++;
        if (obs_err0 !== 1'b0 || obs_rd0 !== 32'hA1B2C3D4) begin
            n_errors++; $display("FAIL err_last_word: err %b rdata %h want 0 a1b2c3d4", obs_err0, obs_rd0);
        end
        d0_addr = 32'd4096;
        tick();
        n_checks++;
        if (obs_read !== 1'b0 || obs_err0 !== 1'b1 || obs_rd0 !== 32'h0) begin
            n_errors++; $display("FAIL err_past_end: read %b err %b rdata %h want 0 1 00000000", obs_read, obs_err0, obs_rd0);
        end
        d0_req = 1'b0;
    endtask

    task automatic test_lock();
        apply_reset();
        d0_req = 1'b1; d0_we = 1'b0; d0_lock = 1'b1; d0_addr = 32'd0;
        d1_req = 1'b1; d1_we = 1'b0; d1_addr = 32'd8;
        tick();
        n_checks++;
        if (obs_gnt !== 2'b01) begin
            n_errors++; $display("FAIL lock_first: gnt %b want 01", obs_gnt);
        end
        d0_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs_gnt !== 2'b00) begin
                n_errors++; $display("FAIL lock_hold[%0d]: gnt %b want 00", i, obs_gnt);
            end
        end
        d0_req = 1'b1; d0_we = 1'b1; d0_lock = 1'b0; d0_wdata = 32'h00000007;
        tick();
        n_checks++;
        if (obs_gnt !== 2'b01 || obs_esc !== 1'b1) begin
            n_errors++; $display("FAIL lock_release: gnt %b esc %b want 01 1", obs_gnt, obs_esc);
        end
        d0_req = 1'b0;
        tick();
        n_checks++;
        if (obs_gnt !== 2'b10 || obs_rd1 !== 32'h00000005) begin
            n_errors++; $display("FAIL lock_p1_after: gnt %b rdata %h want 10 00000005", obs_gnt, obs_rd1);
        end
        d1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        d0_req = 1'b1; d0_we = 1'b0; d0_lock = 1'b1; d0_addr = 32'd0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.p1_rvalid, bus.p0_rvalid} !== 2'b00) begin
            n_errors++; $display("FAIL midreset_rvalid: got %b want 00", {bus.p1_rvalid, bus.p0_rvalid});
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        d0_req = 1'b0; d0_lock = 1'b0;
        d1_req = 1'b1; d1_we = 1'b0; d1_addr = 32'd8;
        tick();
        n_checks++;
        if (obs_gnt !== 2'b10) begin
            n_errors++; $display("FAIL midreset_lock_cleared: gnt %b want 10", obs_gnt);
        end
        d1_req = 1'b0;
        apply_reset();
        d0_req = 1'b1; d0_we = 1'b0; d0_addr = 32'd4;
        tick();
        d0_req = 1'b0;
        d1_req = 1'b1; d1_we = 1'b1; d1_addr = 32'd16; d1_wdata = 32'h12345678;
        drive_bus();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.p1_rvalid, bus.p0_rvalid, bus.p1_gnt, bus.mem_esc} !== 4'b0000) begin
            n_errors++; $display("FAIL midreset_write_blocked: rv %b gnt1 %b esc %b want 00 0 0",
                {bus.p1_rvalid, bus.p0_rvalid}, bus.p1_gnt, bus.mem_esc);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        d0_req = 1'b1; d0_addr = 32'd4;
        d1_we = 1'b0; d1_addr = 32'd8;
        tick();
        n_checks++;
        if (obs_gnt !== 2'b01) begin
            n_errors++; $display("FAIL midreset_pointer: gnt %b want 01", obs_gnt);
        end
        n_checks++;
        if (mem_word(12'd16) !== 32'h0) begin
            n_errors++; $display("FAIL midreset_no_commit: got %h want 00000000", mem_word(12'd16));
        end
        d0_req = 1'b0; d1_req = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'($urandom_range(0, 63));
            1:       return 32'd4084 + 32'($urandom_range(0, 16));
            2:       return 32'h8000_0000 | 32'($urandom_range(0, 255) * 4);
            default: return 32'($urandom_range(0, 15) * 4);
        endcase
    endfunction

    task automatic test_random();
        apply_reset();
        d0_req = 1'b0; d1_req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!d0_req) begin
                d0_req = ($urandom_range(0, 3) != 0); d0_we = 1'($urandom_range(0, 1));
                d0_lock = ($urandom_range(0, 3) == 0); d0_addr = rand_addr(); d0_wdata = $urandom;
            end
            if (!d1_req) begin
                d1_req = ($urandom_range(0, 3) != 0); d1_we = 1'($urandom_range(0, 1));
                d1_addr = rand_addr(); d1_wdata = $urandom;
            end
            tick();
            n_checks++;
            if (obs_gnt !== exp_gnt || obs_rv !== exp_gnt) begin
                n_errors++; $display("FAIL rand_gnt[%0d]: gnt %b rv %b want %b", i, obs_gnt, obs_rv, exp_gnt);
            end
            n_checks++;
            if ({obs_esc, obs_read} !== {exp_esc, exp_read} || {obs_maddr, obs_mval} !== {exp_maddr, exp_mval}) begin
                n_errors++; $display("FAIL rand_mem[%0d]: esc/read %b%b addr %h val %h want %b%b %h %h", i,
                    obs_esc, obs_read, obs_maddr, obs_mval, exp_esc, exp_read, exp_maddr, exp_mval);
            end
            if (exp_win == 0) begin
                n_checks++;
                if (obs_rd0 !== exp_rdata || obs_err0 !== exp_err) begin
                    n_errors++; $display("FAIL rand_p0_resp[%0d]: rdata %h err %b want %h %b", i, obs_rd0, obs_err0, exp_rdata, exp_err);
                end
                d0_req = 1'b0;
            end else if (exp_win == 1) begin
                n_checks++;
                if (obs_rd1 !== exp_rdata || obs_err1 !== exp_err) begin
                    n_errors++; $display("FAIL rand_p1_resp[%0d]: rdata %h err %b want %h %b", i, obs_rd1, obs_err1, exp_rdata, exp_err);
                end
                d1_req = 1'b0;
            end
        end
        d0_req = 1'b0; d1_req = 1'b0;
        tick();
        for (int w = 0; w < 16; w++) begin
            n_checks++;
            if (mem_word(12'(w * 4)) !== ref_rd(32'(w * 4))) begin
                n_errors++; $display("FAIL rand_final_mem[%0d]: got %h want %h", w * 4, mem_word(12'(w * 4)), ref_rd(32'(w * 4)));
            end
        end
        n_checks++;
        if (mem_word(12'd4092) !== ref_rd(32'd4092)) begin
            n_errors++; $display("FAIL rand_final_top: got %h want %h", mem_word(12'd4092), ref_rd(32'd4092));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        model_reset();
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_errors();
        test_lock();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
